// File: rtl/wc_stream_sched.sv
// wc_stream_sched: stride-2 4-sample window sequencer with credit-controlled result buffering for a Winograd F(2,3) core
// ports: clk/rst (async, active high); in_valid/in_ready/in_data sample stream;
//   core_d/core_vld window issue to core; core_z core result CORE_LAT cycles after core_vld;
//   out_valid/out_ready/out_data/out_last buffered result stream; busy activity flag
module wc_stream_sched #(
  parameter int DW = 10,
  parameter int ROW_LEN = 16,
  parameter int CORE_LAT = 2,
  parameter int OBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic [4*DW-1:0]   core_d,
  output logic              core_vld,
  input  logic [2*DW-1:0]   core_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*DW-1:0]   out_data,
  output logic              out_last,
  output logic              busy
);
  localparam int NW = ROW_LEN / 2 - 1;
  localparam int IW = $clog2(NW + 1);
  localparam int AW = $clog2(OBUF_DEPTH);
  localparam int CW = $clog2(OBUF_DEPTH + CORE_LAT + 2);
  typedef enum logic {FILL, STEADY} state_t;
  state_t state;
  logic [1:0] cnt;
  logic phase;
  logic [IW-1:0] widx;
  logic [4*DW-1:0] win;
  logic core_last;
  logic [CORE_LAT-1:0] pv, pl;
  logic [2*DW:0] mem [OBUF_DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  logic [CW-1:0] inflight;
  logic completes, credit_ok, accept, issue, last, push, pop;
  // the issue strobe itself counts as in flight so a credit is taken the moment a window leaves
  always_comb begin
    inflight = CW'(core_vld);
    for (int i = 0; i < CORE_LAT; i++) inflight = inflight + CW'(pv[i]);
  end
  assign credit_ok = (CW'(count) + inflight) < CW'(OBUF_DEPTH);
  assign completes = state == STEADY ? phase : cnt == 2'd3;
  assign in_ready = !rst && (!completes || credit_ok);
  assign accept = in_valid && in_ready;
  assign issue = accept && completes;
  assign last = widx == IW'(NW - 1);
  assign push = pv[CORE_LAT-1];
  assign pop = out_valid && out_ready;
  assign out_valid = count != '0;
  assign out_data = out_valid ? mem[head][2*DW-1:0] : '0;
  assign out_last = out_valid ? mem[head][2*DW] : 1'b0;
  assign busy = state == STEADY || cnt != 2'd0 || core_vld || |pv || out_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      cnt <= '0;
      phase <= 1'b0;
      widx <= '0;
      win <= '0;
      core_d <= '0;
      core_vld <= 1'b0;
      core_last <= 1'b0;
      pv <= '0;
      pl <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      core_vld <= issue;
      if (issue) begin
        core_d <= {in_data, win[4*DW-1:DW]};
        core_last <= last;
      end
      if (accept) begin
        win <= {in_data, win[4*DW-1:DW]};
        if (issue && last) begin
          state <= FILL;
          cnt <= '0;
          phase <= 1'b0;
          widx <= '0;
        end else if (state == FILL) begin
          cnt <= cnt + 2'd1;
          if (issue) begin
            state <= STEADY;
            phase <= 1'b0;
            widx <= widx + IW'(1);
          end
        end else begin
          phase <= !phase;
          if (issue) widx <= widx + IW'(1);
        end
      end
      pv <= CORE_LAT'({pv, core_vld});
      pl <= CORE_LAT'({pl, core_last});
      if (push) tail <= tail + AW'(1);
      if (pop) head <= head + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[tail] <= {pl[CORE_LAT-1], core_z};
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == (AW+1)'(OBUF_DEPTH)));
endmodule
